// File: rtl/config_commit_register_bank_pkg.sv
// config_commit_register_bank_pkg: shared config address width, CTRL/STATUS bit layout and status packer
package config_commit_register_bank_pkg;
  localparam int CFG_ADDR_W = 16;
  localparam int CFG_STATUS_VALID_BIT = 0;
  localparam int CFG_STATUS_OVERFLOW_BIT = 1;
  localparam int CFG_STATUS_COUNT_LSB = 8;
  localparam int CFG_STATUS_COUNT_MSB = 15;
  localparam int CFG_STATUS_NREGS_LSB = 32;
  localparam int CFG_CTRL_COMMIT_BIT = 0;
  localparam int CFG_CTRL_CLEAR_OVF_BIT = 1;
  function automatic logic [63:0] cfg_status(input logic valid, input logic ovf, input logic [7:0] count,
                                             input logic [31:0] nregs);
    cfg_status = '0;
    cfg_status[CFG_STATUS_VALID_BIT] = valid;
    cfg_status[CFG_STATUS_OVERFLOW_BIT] = ovf;
    cfg_status[CFG_STATUS_COUNT_MSB:CFG_STATUS_COUNT_LSB] = count;
    cfg_status[63:CFG_STATUS_NREGS_LSB] = nregs;
  endfunction
endpackage

// File: rtl/config_commit_register_bank_if.sv
// config interfaces: local-address write channel and read request/response channel
interface write_config_i;
  logic                                                valid;
  logic [config_commit_register_bank_pkg::CFG_ADDR_W-1:0] addr;
  logic [63:0]                                         data;
  modport s (input valid, addr, data);
  modport m (output valid, addr, data);
endinterface

interface read_config_i;
  logic [config_commit_register_bank_pkg::CFG_ADDR_W-1:0] read_addr;
  logic                                                read_valid;
  logic                                                read_ready;
  logic [63:0]                                         resp_data;
  logic                                                resp_error;
  logic                                                resp_valid;
  logic                                                resp_ready;
  modport s (input read_addr, read_valid, resp_ready, output read_ready, resp_data, resp_error, resp_valid);
  modport m (output read_addr, read_valid, resp_ready, input read_ready, resp_data, resp_error, resp_valid);
endinterface

// File: rtl/config_read_port.sv
// config_read_port: IDLE/RESP read handshake holding one captured lookup result until consumed
module config_read_port (
  input logic        clk,
  input logic        rst_n,
  read_config_i.s    read_config,
  input logic [63:0] lookup_data_i,
  input logic        lookup_err_i
);
  localparam logic IDLE = 1'b0;
  localparam logic RESP = 1'b1;
  logic        state_q, state_d;
  logic [63:0] data_q, data_d;
  logic        err_q, err_d;
  logic        accept;
  assign accept = state_q == IDLE && read_config.read_valid;
  // capture the lookup on accept and hold it until the response is taken
  always_comb begin
    state_d = accept ? RESP : (state_q == RESP && read_config.resp_ready) ? IDLE : state_q;
    data_d = accept ? (lookup_err_i ? '0 : lookup_data_i) : data_q;
    err_d = accept ? lookup_err_i : err_q;
  end
  // response state and holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
  assign read_config.read_ready = state_q == IDLE;
  assign read_config.resp_valid = state_q == RESP;
  assign read_config.resp_data = data_q;
  assign read_config.resp_error = err_q;
endmodule

// File: rtl/config_commit_register_bank.sv
// config_commit_register_bank: shadow registers with atomic commit into a valid/ready snapshot plus readback
module config_commit_register_bank
  import config_commit_register_bank_pkg::*;
#(
  parameter int NUM_REGS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  write_config_i.s                 write_config,
  read_config_i.s                  read_config,
  output logic [NUM_REGS-1:0][63:0] cfg_data,
  output logic                     cfg_valid,
  input  logic                     cfg_ready
);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [CFG_ADDR_W-1:0] CTRL_ADDR = CFG_ADDR_W'(NUM_REGS);
  logic [NUM_REGS-1:0][63:0] shadow_q, shadow_d, cfg_data_q, cfg_data_d;
  logic                      cfg_valid_q, cfg_valid_d, ovf_q, ovf_d;
  logic [7:0]                count_q, count_d;
  logic                      wr_data, wr_ctrl, commit, clr, load, drop;
  logic [CFG_ADDR_W-1:0]     rd_addr;
  logic [63:0]               status, rd_data;
  assign wr_data = write_config.valid && write_config.addr < CTRL_ADDR;
  assign wr_ctrl = write_config.valid && write_config.addr == CTRL_ADDR;
  assign commit = wr_ctrl && write_config.data[CFG_CTRL_COMMIT_BIT];
  assign clr = wr_ctrl && write_config.data[CFG_CTRL_CLEAR_OVF_BIT];
  assign load = commit && (!cfg_valid_q || cfg_ready);
  assign drop = commit && cfg_valid_q && !cfg_ready;
  // shadow update, snapshot/handshake, commit counter and sticky overflow
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_REGS; i++)
      if (wr_data && write_config.addr == CFG_ADDR_W'(i)) shadow_d[i] = write_config.data;
    cfg_data_d = load ? shadow_q : cfg_data_q;
    cfg_valid_d = load ? 1'b1 : (cfg_valid_q && cfg_ready) ? 1'b0 : cfg_valid_q;
    count_d = load ? count_q + 8'd1 : count_q;
    ovf_d = drop || (ovf_q && !clr);
  end
  // bank state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cfg_data_q <= '0;
      cfg_valid_q <= 1'b0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cfg_data_q <= cfg_data_d;
      cfg_valid_q <= cfg_valid_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end
  assign status = cfg_status(cfg_valid_q, ovf_q, count_q, 32'(NUM_REGS));
  assign rd_addr = read_config.read_addr;
  assign rd_data = rd_addr < CTRL_ADDR ? shadow_q[rd_addr[IW-1:0]] : rd_addr == CTRL_ADDR ? status : '0;
  config_read_port u_read_port (
    .clk          (clk),
    .rst_n        (rst_n),
    .read_config  (read_config),
    .lookup_data_i(rd_data),
    .lookup_err_i (rd_addr > CTRL_ADDR)
  );
  assign cfg_data = cfg_data_q;
  assign cfg_valid = cfg_valid_q;
endmodule

// File: tb/tb_config_commit_register_bank.sv
// tb_config_commit_register_bank: scoreboard bench checking writes, commits, overflow and read handshake
module tb_config_commit_register_bank;
  import config_commit_register_bank_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_ready = 1'b0;
  logic [N-1:0][63:0] cfg_data;
  logic cfg_valid;
  write_config_i wc ();
  read_config_i  rc ();
  config_commit_register_bank #(.NUM_REGS(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_config(wc),
    .read_config (rc),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready)
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  logic [N-1:0][63:0] msh, mdata;
  logic mv, movf;
  logic [7:0] mcnt;
  logic [63:0] exp_d[$];
  logic exp_e[$];

  task automatic mreset();
    msh = '0;
    mdata = '0;
    mv = 1'b0;
    movf = 1'b0;
    mcnt = '0;
  endtask

  function automatic logic [63:0] mstatus();
    return {32'(N), 16'h0, mcnt, 6'h0, movf, mv};
  endfunction

  task automatic step();
    logic commit, clr, can;
    if (!rst_n) mreset();
    else begin
      commit = wc.valid && wc.addr == 16'(N) && wc.data[0];
      clr = wc.valid && wc.addr == 16'(N) && wc.data[1];
      can = !mv || cfg_ready;
      if (commit && can) begin
        mdata = msh;
        mv = 1'b1;
        mcnt = mcnt + 8'd1;
      end else if (mv && cfg_ready) mv = 1'b0;
      movf = (commit && !can) || (movf && !clr);
      if (wc.valid && wc.addr < 16'(N)) msh[wc.addr[1:0]] = wc.data;
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [CFG_ADDR_W-1:0] a, input logic [63:0] d);
    wc.valid = 1'b1;
    wc.addr = a;
    wc.data = d;
    step();
    wc.valid = 1'b0;
  endtask

  task automatic push_exp(input logic [CFG_ADDR_W-1:0] a);
    if (a < 16'(N)) begin
      exp_d.push_back(msh[a[1:0]]);
      exp_e.push_back(1'b0);
    end else if (a == 16'(N)) begin
      exp_d.push_back(mstatus());
      exp_e.push_back(1'b0);
    end else begin
      exp_d.push_back(64'h0);
      exp_e.push_back(1'b1);
    end
  endtask

  task automatic rd(input logic [CFG_ADDR_W-1:0] a, input int hold);
    logic [63:0] ed;
    logic ee;
    rc.read_addr = a;
    rc.read_valid = 1'b1;
    checks++;
    if (rc.read_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_ready_idle addr=%0d got=%b want=1", a, rc.read_ready);
    end
    push_exp(a);
    step();
    rc.read_valid = 1'b0;
    wc.valid = 1'b0;
    checks++;
    if (rc.resp_valid !== 1'b1 || rc.read_ready !== 1'b0) begin
      errors++;
      $display("FAIL rd_resp_start addr=%0d resp_valid=%b read_ready=%b want 1/0", a, rc.resp_valid, rc.read_ready);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if (rc.resp_valid !== 1'b1 || rc.read_ready !== 1'b0 || rc.resp_data !== exp_d[0] || rc.resp_error !== exp_e[0]) begin
        errors++;
        $display("FAIL rd_hold addr=%0d cyc=%0d valid=%b ready=%b data=%h err=%b want 1/0 %h %b",
                 a, i, rc.resp_valid, rc.read_ready, rc.resp_data, rc.resp_error, exp_d[0], exp_e[0]);
      end
    end
    checks++;
    if (exp_d.size() == 0) begin
      errors++;
      $display("FAIL rd_scoreboard_empty addr=%0d", a);
    end else begin
      ed = exp_d.pop_front();
      ee = exp_e.pop_front();
      if (rc.resp_data !== ed || rc.resp_error !== ee) begin
        errors++;
        $display("FAIL rd_data addr=%0d got=%h err=%b want=%h err=%b", a, rc.resp_data, rc.resp_error, ed, ee);
      end
    end
    rc.resp_ready = 1'b1;
    step();
    rc.resp_ready = 1'b0;
    checks++;
    if (rc.resp_valid !== 1'b0 || rc.read_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_done addr=%0d resp_valid=%b read_ready=%b want 0/1", a, rc.resp_valid, rc.read_ready);
    end
  endtask

  task automatic chk_cfg(input string name);
    checks++;
    if (cfg_valid !== mv || cfg_data !== mdata) begin
      errors++;
      $display("FAIL %s cfg_valid=%b cfg_data=%h want %b %h", name, cfg_valid, cfg_data, mv, mdata);
    end
  endtask

  task automatic test_reset();
    wc.valid = 1'b0;
    wc.addr = '0;
    wc.data = '0;
    rc.read_addr = '0;
    rc.read_valid = 1'b0;
    rc.resp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++;
    if (cfg_valid !== 1'b0 || rc.read_ready !== 1'b1 || rc.resp_valid !== 1'b0 || rc.resp_error !== 1'b0 || rc.resp_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs cfg_valid=%b read_ready=%b resp_valid=%b resp_error=%b resp_data=%h want 0/1/0/0/0",
               cfg_valid, rc.read_ready, rc.resp_valid, rc.resp_error, rc.resp_data);
    end
    chk_cfg("reset_cfg");
    rd(0, 0);
    rd(16'(N), 0);
  endtask

  task automatic test_readback();
    wr(2, 64'hDEAD_BEEF);
    rd(2, 3);
  endtask

  task automatic test_commit();
    for (int i = 0; i < N; i++) wr(16'(i), 64'h1234_0000_0000_0000 | 64'(i * 7 + 1));
    wr(16'(N), 64'h1);
    chk_cfg("commit_load");
    wr(0, 64'hABCD_0000);
    chk_cfg("commit_stable");
    rd(0, 0);
  endtask

  task automatic test_overflow();
    wr(16'(N), 64'h1);
    chk_cfg("ovf_drop");
    rd(16'(N), 0);
    wr(16'(N), 64'h2);
    rd(16'(N), 1);
    wr(16'(N), 64'h3);
    rd(16'(N), 0);
    wr(16'(N), 64'h2);
  endtask

  task automatic test_coincident();
    wr(1, 64'h5555_AAAA_5555_AAAA);
    cfg_ready = 1'b1;
    wr(16'(N), 64'h1);
    cfg_ready = 1'b0;
    chk_cfg("coincident_load");
    rd(16'(N), 0);
    cfg_ready = 1'b1;
    step();
    cfg_ready = 1'b0;
    chk_cfg("accept_clear");
    rd(16'(N), 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) rd(16'(i), 0);
  endtask

  task automatic test_same_cycle();
    wc.valid = 1'b1;
    wc.addr = 3;
    wc.data = 64'hFEED_F00D_0000_0003;
    rd(3, 0);
    rd(3, 0);
  endtask

  task automatic test_bad_addr();
    rd(16'(N + 3), 2);
    wr(16'(N + 3), '1);
    for (int i = 0; i <= N; i++) rd(16'(i), 0);
    chk_cfg("bad_addr_cfg");
  endtask

  task automatic test_reset_mid_read();
    wr(16'(N), 64'h1);
    rc.read_addr = 2;
    rc.read_valid = 1'b1;
    step();
    rc.read_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rc.resp_valid !== 1'b0 || rc.read_ready !== 1'b1 || cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort resp_valid=%b read_ready=%b cfg_valid=%b want 0/1/0", rc.resp_valid, rc.read_ready, cfg_valid);
    end
    @(negedge clk);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rc.resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_resp cyc=%0d resp_valid=%b want 0", i, rc.resp_valid);
      end
    end
    chk_cfg("reset_mid_cfg");
  endtask

  task automatic test_wrap();
    cfg_ready = 1'b1;
    for (int i = 0; i < 256; i++) wr(16'(N), 64'h1);
    cfg_ready = 1'b0;
    chk_cfg("wrap_cfg");
    rd(16'(N), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    mreset();
    test_reset();
    test_readback();
    test_commit();
    test_overflow();
    test_coincident();
    test_back_to_back();
    test_same_cycle();
    test_bad_addr();
    test_reset_mid_read();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/config_commit_register_bank.md
# config_commit_register_bank

Software-programmable register bank that sits directly downstream of the global configuration block, occupying one configuration address space. It consumes one `write_config_i` / `read_config_i` pair and stores software writes in shadow registers. On a commit command it snapshots all shadow registers atomically into a valid/ready output, so user datapaths never observe a half-written configuration. Software can read back every shadow register plus a status register.

## Interface
Parameters:
- `NUM_REGS`, 4: number of 64-bit data registers. The address space size is `NUM_REGS + 1`, and this value goes in the global config's address-space-size list.

Ports:
- `clk`  input  1  design clock; everything is synchronous to it.
- `rst_n`  input  1  reset: asynchronous, active-low.
- `write_config`  `write_config_i.s`  —  write requests: `valid`, local `addr`, 64-bit `data`.
- `read_config`  `read_config_i.s`  —  read requests and responses: `read_addr/read_valid/read_ready`, `resp_data/resp_error/resp_valid/resp_ready`.
- `cfg_data`  output  `NUM_REGS`×64  committed configuration snapshot.
- `cfg_valid`  output  1  snapshot pending for the consumer.
- `cfg_ready`  input  1  consumer accepts the snapshot.

## Operation
Addresses:
- Addresses arrive local (0-based), as delivered by the upstream splitters.
- Addresses `0..NUM_REGS-1` are data registers; address `NUM_REGS` is CTRL/STATUS.

Writes (single-cycle, no backpressure):
- Data address: shadow[addr] ← data on the edge where `valid`=1.
- CTRL, `data[0]`=1: commit.
- CTRL, `data[1]`=1: clear the sticky overflow bit.
- Writes to addresses > `NUM_REGS` are silently dropped.

Commit:
- If `cfg_valid`=0, or `cfg_ready`=1 in the same cycle: `cfg_data` ← shadow (all registers), `cfg_valid` ← 1, commit_count ← commit_count+1.
- If `cfg_valid`=1 and `cfg_ready`=0: the commit is dropped, overflow ← 1, and the count is unchanged.
- commit_count is 8 bits and wraps 255→0.

Output handshake:
- `cfg_valid` and `cfg_data` hold stable until `cfg_valid && cfg_ready`. The cycle after acceptance, `cfg_valid` = 0 unless a commit coincided.

STATUS read layout:
- bit0 = `cfg_valid`
- bit1 = overflow
- bits[15:8] = commit_count
- bits[63:32] = `NUM_REGS`
- all other bits 0.

Read FSM, two states:
- IDLE: `read_ready`=1. On `read_valid`, capture the response data from current contents and go to RESP.
- RESP: `read_ready`=0, `resp_valid`=1. On `resp_ready`, return to IDLE.
- At most one read is outstanding.
- Address > `NUM_REGS`: `resp_error`=1, `resp_data`=0.

Reset values:
- shadow, `cfg_data`, commit_count, overflow: 0.
- `cfg_valid`=0.
- FSM in IDLE, so `read_ready`=1.
- `resp_valid`=0, `resp_error`=0, `resp_data`=0.
- Reset asserted mid-read aborts the response immediately; no response is emitted after release.

## Timing
- Write: the value is visible in shadow/readback from the cycle after `valid`.
- Commit: `cfg_valid` rises the cycle after the CTRL write.
- Read latency: request accepted at edge N, `resp_valid`=1 from cycle N+1, held with stable data/error until `resp_ready`.
- Back-to-back reads: best case one response every 2 cycles (IDLE, RESP).
- Write and read to the same address in the same cycle: the read returns the pre-write value.
- A CTRL write with both bit0 and bit1 set: clear, then a possible new overflow from this commit. The result is overflow = (this commit dropped).
- The read response for STATUS reflects state at the accept edge, before any same-cycle commit.

## Structure
- Shared config package holds:
  - `CFG_STATUS_VALID_BIT`, `CFG_STATUS_OVERFLOW_BIT`
  - `CFG_STATUS_COUNT_LSB/MSB`, `CFG_STATUS_NREGS_LSB`
  - `CFG_CTRL_COMMIT_BIT`, `CFG_CTRL_CLEAR_OVF_BIT`
- Sub-module `config_read_port`: the IDLE/RESP read FSM with response holding register. It takes a combinational lookup value plus error flag and drives the `read_config_i` handshake; other register banks reuse it.

## Test plan
- Reset release -> `cfg_valid`=0, `read_ready`=1, `resp_valid`=0; reading address 0 returns 0, and reading STATUS returns `NUM_REGS`<<32.
- Write 0xDEAD_BEEF to reg 2, read reg 2 with `resp_ready` held low for 3 cycles -> response 0xDEAD_BEEF held stable, `resp_error`=0, `read_ready`=0 throughout.
- Write regs 0..3, commit with `cfg_ready`=0 -> `cfg_valid`=1 next cycle, `cfg_data` equals written values. A later write to reg 0 leaves `cfg_data[0]` unchanged.
- Second commit while pending and `cfg_ready`=0 -> STATUS = 0x3 \| (1<<8) \| (`NUM_REGS`<<32). Writing CTRL=0x2 clears bit1.
- Commit coincident with `cfg_ready`=1 while pending -> `cfg_valid` stays 1, new snapshot loaded, no overflow, count increments. After 256 commits, the count reads 0.
- Read address `NUM_REGS`+3 -> `resp_error`=1, `resp_data`=0. Write to that address -> no state change.
